data_memory: RTL and testbench



---
 rtl/data_memory.sv | 42 ++++
 tb/tb_data_memory.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_memory                                                              |
// | Word-organised MIPS data memory. Writes are synchronous, reads are       |
// | combinational, and an asynchronous clear empties the whole array.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int INDEX_BITS  = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData
);

  logic [31:0]           r_mem [DEPTH_WORDS];
  logic [INDEX_BITS-1:0] w_index;
  logic                  w_unused;

  // Byte offset and high bits are dropped, so addresses wrap and alignment is ignored.
  assign w_index  = address[INDEX_BITS+1:2];
  assign w_unused = ^{address[31:INDEX_BITS+2], address[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else if (MemWrite) begin
      r_mem[w_index] <= WriteData;
    end
  end

  assign ReadData = (MemRead && reset) ? r_mem[w_index] : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_memory                                                           |
// | Directed self-checking bench for data_memory.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  int n_chk;
  int n_pass;

  data_memory #(
    .DEPTH_WORDS(256),
    .INDEX_BITS (8)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .address  (address),
    .WriteData(WriteData),
    .ReadData (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    address = addr;
    MemRead = 1'b1;
    #1;
    check(tag, ReadData, exp);
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    address   = addr;
    WriteData = data;
    edge_wait();
    MemWrite  = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    reset     = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b1;
    address   = 32'd4;
    WriteData = 32'h0;
    #12;
    check("rd_in_reset", ReadData, 32'h0);
    edge_wait();
    reset = 1'b1;
    edge_wait();

    read_chk("rst_clr_0",    32'd0,    32'h0);
    read_chk("rst_clr_4",    32'd4,    32'h0);
    read_chk("rst_clr_1020", 32'd1020, 32'h0);

    // write then combinational read
    write_word(32'd4, 32'h1234_5678);
    read_chk("wr_rd_4", 32'd4, 32'h1234_5678);
    MemRead = 1'b0;
    #1;
    check("rd_gate_off", ReadData, 32'h0);

    // simultaneous read/write at word 8
    address   = 32'd8;
    WriteData = 32'hDEAD_BEEF;
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    #1;
    check("rw_before_edge", ReadData, 32'h0);
    edge_wait();
    check("rw_after_edge", ReadData, 32'hDEAD_BEEF);
    MemWrite = 1'b0;
    read_chk("rw_word4_kept", 32'd4, 32'h1234_5678);

    // address decode: low bits ignored, high bits wrap
    write_word(32'h0000_000B, 32'hA5A5_A5A5);
    read_chk("dec_low_bits", 32'd8, 32'hA5A5_A5A5);
    write_word(32'h0000_0400, 32'h1111_1111);
    read_chk("dec_wrap", 32'd0, 32'h1111_1111);
    read_chk("dec_word4_kept", 32'd4, 32'h1234_5678);

    // write disabled while address/data wander
    MemWrite = 1'b0;
    for (int i = 0; i < 5; i++) begin
      address   = 32'(i * 4);
      WriteData = 32'hFFFF_0000 | 32'(i);
      edge_wait();
    end
    read_chk("wdis_0", 32'd0, 32'h1111_1111);
    read_chk("wdis_4", 32'd4, 32'h1234_5678);
    read_chk("wdis_8", 32'd8, 32'hA5A5_A5A5);

    // reset asserted before a pending write edge
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    address   = 32'd4;
    WriteData = 32'hFFFF_FFFF;
    #1;
    reset = 1'b0;
    #1;
    check("rst_async_rd", ReadData, 32'h0);
    edge_wait();
    check("rst_held_rd", ReadData, 32'h0);
    MemWrite = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    read_chk("rst_mid_4", 32'd4, 32'h0);
    read_chk("rst_mid_8", 32'd8, 32'h0);
    read_chk("rst_mid_0", 32'd0, 32'h0);

    // first write after release is honoured
    write_word(32'd12, 32'h0BAD_F00D);
    read_chk("post_rst_wr", 32'd12, 32'h0BAD_F00D);
    read_chk("post_rst_wrap", 32'd1036, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
